// File: rtl/addsub_result_stage.sv
// Registered result stage behind the add/sub datapath: derives {N,Z,C,V}, optionally
// saturates on signed overflow, buffers results in a 2-entry skid FIFO and counts overflows.
module addsub_result_stage #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     SUM,
  input  logic             C_out,
  input  logic             O,
  input  logic             Add_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic [3:0]       out_flags,
  input  logic             clr_stats,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  // Entry layout: {result[W-1:0], N, Z, C, V}
  localparam int EW = W + 4;

  // For subtraction the adder's carry is inverted, so C becomes a borrow flag.
  function automatic logic [EW-1:0] make_entry(
    input logic [W-1:0] sum,
    input logic         c_out,
    input logic         o,
    input logic         ctrl
  );
    logic [W-1:0] res;
    logic         v;
    logic         c;
    v = o;
    c = c_out ^ ctrl;
    if (SATURATE && v) begin
      res = sum[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    end else begin
      res = sum;
    end
    return {res, res[W-1], (res == {W{1'b0}}), c, v};
  endfunction

  logic [EW-1:0]    mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push_s;
  logic             pop_s;
  logic [EW-1:0]    entry_s;
  logic             ovf_sticky_q;
  logic             ovf_sticky_d;
  logic [CNT_W-1:0] ovf_count_q;
  logic [CNT_W-1:0] ovf_count_d;

  assign in_ready   = (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign out_result = mem_q[rd_ptr_q][EW-1:4];
  assign out_flags  = mem_q[rd_ptr_q][3:0];
  assign ovf_sticky = ovf_sticky_q;
  assign ovf_count  = ovf_count_q;

  // Handshake decode, occupancy and statistics next-state
  always_comb begin
    push_s       = in_valid & in_ready;
    pop_s        = out_valid & out_ready;
    entry_s      = make_entry(SUM, C_out, O, Add_ctrl);
    count_d      = count_q + {1'b0, push_s} - {1'b0, pop_s};
    ovf_sticky_d = ovf_sticky_q;
    ovf_count_d  = ovf_count_q;
    if (clr_stats) begin
      ovf_sticky_d = 1'b0;
      ovf_count_d  = {CNT_W{1'b0}};
    end else if (push_s && entry_s[0]) begin
      ovf_sticky_d = 1'b1;
      if (ovf_count_q != {CNT_W{1'b1}}) begin
        ovf_count_d = ovf_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        ovf_count_d = ovf_count_q;
      end
    end else begin
      ovf_sticky_d = ovf_sticky_q;
      ovf_count_d  = ovf_count_q;
    end
  end

  // FIFO storage, pointers and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]     <= {EW{1'b0}};
      mem_q[1]     <= {EW{1'b0}};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      ovf_sticky_q <= 1'b0;
      ovf_count_q  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= entry_s;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q      <= count_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

endmodule
